lin_ahb_sram_slv: RTL and testbench
===================================

# lin_ahb_sram_slv

AHB slave responder serving 32-bit single transfers and bursts from a synchronous single-port SRAM. Sits at the slave end of the lin_ahb bus, opposite the master-side VIP. Samples address phases and inserts a programmable number of wait states. Returns OKAY or two-cycle ERROR responses and drives a simple word-addressed SRAM port with byte enables.

## Interface
Parameters:
- ADDR_WIDTH, 32, haddr width
- MEM_BYTES, 65536, backing SRAM size in bytes; power of two, at least 4
- WAIT_CYCLES, 0, extra wait states per transfer, 0..7

Ports:
- hclk  in  1  bus clock; all logic is on its rising edge
- hreset  in  1  asynchronous, active-high reset
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  transfer address
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1 = write
- hsize  in  3  0=byte, 1=half, 2=word; larger values are illegal
- hburst  in  3  accepted, ignored; every beat is decoded on its own
- hwdata  in  32  write data, valid throughout the data phase
- hready_in  in  1  bus-level hready
- hreadyout  out  1  slave ready
- hresp  out  2  OKAY=00, ERROR=01; RETRY and SPLIT are never driven
- hrdata  out  32  read data
- sram_cs  out  1  SRAM access strobe, one cycle per access
- sram_we  out  1  1 = write
- sram_addr  out  log2(MEM_BYTES)-2  word address, taken from haddr
- sram_be  out  4  byte enables
- sram_wdata  out  32  equals hwdata
- sram_rdata  in  32  read data, valid the cycle after a read strobe

## Operation
- Address phase is accepted when hsel & hready_in & htrans[1]. Accepted phases register haddr, hwrite, hsize and the decoded byte enables.
- IDLE or BUSY, or an unselected slave, gives a zero-wait OKAY and does not touch the SRAM.
- The transfer is an error when any of these holds:
  - haddr >= MEM_BYTES
  - hsize > 2
  - half-word with haddr[0]=1
  - word with haddr[1:0]!=0
- Byte enables:
  - byte: bit haddr[1:0]
  - half: 0011 when haddr[1]=0, 1100 when haddr[1]=1
  - word: 1111
- States:
  - IDLE: no data phase outstanding. hreadyout=1, hresp=OKAY.
  - WAIT: counter nonzero. hreadyout=0, hresp=OKAY. Counter decrements each cycle.
  - ERR1: hreadyout=0, hresp=ERROR. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=ERROR. Goes to IDLE, or to WAIT/ERR1 when a new phase is accepted this cycle.
- Transitions on acceptance:
  - Error transfer: go to ERR1.
  - Write: load WAIT_CYCLES.
  - Read: load WAIT_CYCLES+1.
  - A loaded value of 0 stays in IDLE, i.e. a zero-wait data phase.
- SRAM strobe:
  - Issued in the first data-phase cycle only: sram_cs=1, sram_we=hwrite.
  - Write data comes straight from hwdata.
  - sram_rdata is captured into the hrdata register the next cycle.
  - hrdata holds its value until the next read capture.
- Error transfers never assert sram_cs.

## Timing
- Reset values: hreadyout=1, hresp=00, hrdata=0, sram_cs=0, sram_we=0, sram_be=0, state IDLE, counter 0.
- Reset mid-transfer: state is abandoned at once. A write whose strobe has not yet issued is dropped.
- Write latency: WAIT_CYCLES low-hreadyout cycles. The strobe falls in the first data-phase cycle. With WAIT_CYCLES=0 the strobe and the hreadyout=1 completion fall in the same cycle.
- Read latency: WAIT_CYCLES+1 low-hreadyout cycles. hrdata is valid in the hreadyout=1 cycle.
- Back-to-back: a new address phase may be accepted in the same cycle that the prior data phase completes (hreadyout=1). No dead cycle is inserted.
- A read immediately after a write to the same word returns the new data, because SRAM accesses are serialized in data-phase order.
- While hreadyout=0, address-phase inputs are not sampled; hready_in is low.
- During ERR1 the master may replace its pending transfer with IDLE. Only what is presented while hready_in=1 counts.

## Structure
- lin_ahb_pkg holds:
  - htrans, hresp and hsize encodings
  - the state enum {IDLE, WAIT, ERR1, ERR2}
  - the 3-bit wait-counter type
- Sub-module lin_ahb_slv_be_dec is a combinational decoder: (haddr[1:0], hsize) -> (sram_be, align_err).
- lin_ahb_sram_slv holds the FSM, counter, registered controls and hrdata register.

## Test plan
- After reset with no traffic, check hreadyout=1, hresp=00, hrdata=0, sram_cs=0. Assert hreset mid-WAIT: outputs return to reset values within the same cycle.
- WAIT_CYCLES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Write completes zero-wait with sram_be=1111 and sram_addr=4. Read shows one wait state and returns 0xDEADBEEF.
- WAIT_CYCLES=2: write byte 0xA5 to 0x23. Expect 2 wait cycles and sram_be=1000. A following word read of 0x20 shows 3 wait states and returns the byte in bits [31:24].
- Word read of 0x0002 (misaligned): expect ERR1 then ERR2 and no sram_cs. A NONSEQ presented during ERR2 is accepted normally.
- Read of address MEM_BYTES (0x10000), and a transfer with hsize=3: each gets a two-cycle ERROR and no SRAM strobe.
- INCR4 burst of words from 0x40 with one BUSY inserted after beat 2. The BUSY gets a zero-wait OKAY with no strobe. Four strobes hit sram_addr 16..19 in order.

Source files
------------

// File: rtl/lin_ahb_pkg.sv
// Shared encodings for the lin_ahb SRAM slave: bus codes, FSM states and
// the wait-state counter type.
package lin_ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   // RETRY and SPLIT exist on the bus but this slave never drives them
   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_e;

   typedef logic [2:0] wcnt_t;

endpackage

// File: rtl/lin_ahb_sram_slv_if.sv
// AHB slave-side bus bundle; the master modport is used by whatever drives
// address phases, the slave modport by lin_ahb_sram_slv.
interface lin_ahb_sram_slv_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [31:0]           hwdata;
   logic                  hready_in;
   logic                  hreadyout;
   logic [1:0]            hresp;
   logic [31:0]           hrdata;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
      output hreadyout, hresp, hrdata
   );
endinterface

// File: rtl/lin_ahb_slv_be_dec.sv
// Byte-lane decoder: turns the low address bits and hsize into SRAM byte
// enables and flags half/word transfers that are not naturally aligned.
module lin_ahb_slv_be_dec
   import lin_ahb_pkg::*;
(
   input  logic [1:0] i_addr,
   input  logic [2:0] i_size,
   output logic [3:0] o_be,
   output logic       o_align_err
);

   always_comb begin
      o_be        = 4'b0000;
      o_align_err = 1'b0;
      case (i_size)
         HSIZE_BYTE: o_be = 4'b0001 << i_addr;
         HSIZE_HALF: begin
            o_be        = i_addr[1] ? 4'b1100 : 4'b0011;
            o_align_err = i_addr[0];
         end
         HSIZE_WORD: begin
            o_be        = 4'b1111;
            o_align_err = |i_addr;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lin_ahb_sram_slv.sv
// AHB slave fronting a synchronous single-port SRAM: programmable wait
// states, two-cycle ERROR responses and one SRAM strobe per data phase.
module lin_ahb_sram_slv
   import lin_ahb_pkg::*;
#(
   parameter  int ADDR_WIDTH  = 32,
   parameter  int MEM_BYTES   = 65536,
   parameter  int WAIT_CYCLES = 0,
   localparam int SAW         = ($clog2(MEM_BYTES) > 2) ? $clog2(MEM_BYTES) - 2 : 1
) (
   input  logic                hclk,
   input  logic                hreset,
   lin_ahb_sram_slv_if.slave   ahb,
   output logic                sram_cs,
   output logic                sram_we,
   output logic [SAW-1:0]      sram_addr,
   output logic [3:0]          sram_be,
   output logic [31:0]         sram_wdata,
   input  logic [31:0]         sram_rdata
);

   // WAIT holds "low cycles still to come after this one", so a read's
   // WAIT_CYCLES+1 low cycles fit the 3-bit counter even at WAIT_CYCLES=7.
   localparam wcnt_t W_RD = wcnt_t'(WAIT_CYCLES);
   localparam wcnt_t W_WR = wcnt_t'(WAIT_CYCLES - 1);

   state_e          r_state;
   wcnt_t           r_cnt;
   logic            r_hready;
   hresp_e          r_hresp;
   logic            r_cs;
   logic            r_we;
   logic [SAW-1:0]  r_addr;
   logic [3:0]      r_be;
   logic            r_rd_pend;
   logic [31:0]     r_hrdata;

   logic            w_accept;
   logic            w_size_err;
   logic            w_addr_err;
   logic            w_align_err;
   logic            w_err;
   logic [3:0]      w_be;
   logic            w_unused;

   lin_ahb_slv_be_dec u_be_dec (
      .i_addr      (ahb.haddr[1:0]),
      .i_size      (ahb.hsize),
      .o_be        (w_be),
      .o_align_err (w_align_err)
   );

   assign w_accept   = ahb.hsel & ahb.hready_in & ahb.htrans[1];
   assign w_size_err = ahb.hsize > HSIZE_WORD;
   assign w_addr_err = {1'b0, ahb.haddr} >= (ADDR_WIDTH + 1)'(MEM_BYTES);
   assign w_err      = w_size_err | w_addr_err | w_align_err;
   assign w_unused   = ^{ahb.htrans[0], ahb.hburst};

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_hready  <= 1'b1;
         r_hresp   <= HRESP_OKAY;
         r_cs      <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_be      <= '0;
         r_rd_pend <= 1'b0;
         r_hrdata  <= '0;
      end else begin
         r_cs      <= 1'b0;
         r_we      <= 1'b0;
         r_rd_pend <= r_cs & ~r_we;
         if (r_rd_pend)
            r_hrdata <= sram_rdata;

         case (r_state)
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_state  <= ST_IDLE;
                  r_hready <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            ST_ERR1: begin
               r_state  <= ST_ERR2;
               r_hready <= 1'b1;
               r_hresp  <= HRESP_ERROR;
            end
            default: begin
               // IDLE and ERR2 both complete a phase and may accept the next
               r_state  <= ST_IDLE;
               r_hready <= 1'b1;
               r_hresp  <= HRESP_OKAY;
               if (w_accept) begin
                  if (w_err) begin
                     r_state  <= ST_ERR1;
                     r_hready <= 1'b0;
                     r_hresp  <= HRESP_ERROR;
                  end else begin
                     r_cs   <= 1'b1;
                     r_we   <= ahb.hwrite;
                     r_addr <= SAW'(ahb.haddr >> 2);
                     r_be   <= w_be;
                     if (!ahb.hwrite || WAIT_CYCLES != 0) begin
                        r_state  <= ST_WAIT;
                        r_hready <= 1'b0;
                        r_cnt    <= ahb.hwrite ? W_WR : W_RD;
                     end
                  end
               end
            end
         endcase
      end
   end

   // Read data bypasses the holding register in the cycle it arrives so a
   // zero-wait-state read still completes after a single low cycle.
   assign ahb.hreadyout = r_hready;
   assign ahb.hresp     = r_hresp;
   assign ahb.hrdata    = r_rd_pend ? sram_rdata : r_hrdata;

   assign sram_cs    = r_cs;
   assign sram_we    = r_we;
   assign sram_addr  = r_addr;
   assign sram_be    = r_be;
   assign sram_wdata = ahb.hwdata;

endmodule

// File: tb/tb_lin_ahb_sram_slv.sv
// Bench for lin_ahb_sram_slv: two instances (0 and 2 wait states), directed
// vector tables, a reset-in-WAIT sequence and randomized traffic.
module tb_lin_ahb_sram_slv;
   import lin_ahb_pkg::*;

   localparam int AW  = 32;
   localparam int MB  = 65536;
   localparam int SAW = 14;

   logic hclk = 1'b0;
   logic hreset;
   always #5 hclk = ~hclk;

   logic            m_hsel   [2];
   logic [31:0]     m_haddr  [2];
   logic [1:0]      m_htrans [2];
   logic            m_hwrite [2];
   logic [2:0]      m_hsize  [2];
   logic [31:0]     m_hwdata [2];

   logic            s_rdy    [2];
   logic [1:0]      s_resp   [2];
   logic [31:0]     s_rdata  [2];
   logic            s_cs     [2];
   logic            s_we     [2];
   logic [SAW-1:0]  s_addr   [2];
   logic [3:0]      s_be     [2];
   logic [31:0]     s_wdata  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      lin_ahb_sram_slv_if #(.ADDR_WIDTH(AW)) bus ();
      logic [31:0] smem [MB/4];
      logic [31:0] srd;

      assign bus.hsel      = m_hsel[g];
      assign bus.haddr     = m_haddr[g];
      assign bus.htrans    = m_htrans[g];
      assign bus.hwrite    = m_hwrite[g];
      assign bus.hsize     = m_hsize[g];
      assign bus.hburst    = 3'b011;
      assign bus.hwdata    = m_hwdata[g];
      assign bus.hready_in = bus.hreadyout;
      assign s_rdy[g]      = bus.hreadyout;
      assign s_resp[g]     = bus.hresp;
      assign s_rdata[g]    = bus.hrdata;

      lin_ahb_sram_slv #(.ADDR_WIDTH(AW), .MEM_BYTES(MB), .WAIT_CYCLES(g * 2)) u_dut (
         .hclk       (hclk),
         .hreset     (hreset),
         .ahb        (bus),
         .sram_cs    (s_cs[g]),
         .sram_we    (s_we[g]),
         .sram_addr  (s_addr[g]),
         .sram_be    (s_be[g]),
         .sram_wdata (s_wdata[g]),
         .sram_rdata (srd)
      );

      initial begin
         srd = '0;
         for (int i = 0; i < MB/4; i++) smem[i] = '0;
      end

      always @(posedge hclk) begin
         if (s_cs[g]) begin
            if (s_we[g]) begin
               for (int b = 0; b < 4; b++)
                  if (s_be[g][b]) smem[s_addr[g]][8*b +: 8] <= s_wdata[g][8*b +: 8];
            end else begin
               srd <= smem[s_addr[g]];
            end
         end
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic [31:0] wdata;
      logic        e_err;
      logic [3:0]  e_be;
      logic [13:0] e_saddr;
      int          e_low;
      logic [31:0] e_rdata;
   } vec_t;

   typedef struct {
      int          low;
      logic        resp_ok;
      logic        cs_first;
      logic        we;
      logic [13:0] saddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          extra_cs;
   } res_t;

   vec_t       q_in  [$];
   res_t       q_res [$];
   int         stray;
   int         total;
   int         bad;
   logic [7:0] mref [int];

   function automatic vec_t mk(logic [31:0] addr, logic wr, logic [2:0] size, logic [1:0] trans,
                               logic [31:0] wdata, logic e_err, logic [3:0] e_be,
                               logic [13:0] e_saddr, int e_low, logic [31:0] e_rdata);
      vec_t v;
      v.addr = addr; v.wr = wr; v.size = size; v.trans = trans; v.wdata = wdata;
      v.e_err = e_err; v.e_be = e_be; v.e_saddr = e_saddr; v.e_low = e_low; v.e_rdata = e_rdata;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic present(input int d, input int i);
      if (i >= 0 && i < q_in.size()) begin
         m_hsel[d]   = 1'b1;
         m_haddr[d]  = q_in[i].addr;
         m_htrans[d] = q_in[i].trans;
         m_hwrite[d] = q_in[i].wr;
         m_hsize[d]  = q_in[i].size;
      end else begin
         m_hsel[d]   = 1'b0;
         m_haddr[d]  = $urandom;
         m_htrans[d] = 2'($urandom);
         m_hwrite[d] = 1'($urandom);
         m_hsize[d]  = 3'($urandom);
      end
   endtask

   // Pipelined master: next address phase overlaps the current data phase.
   task automatic run_q(input int d);
      int   n, ip, dpi, cyc, guard;
      bit   dp;
      res_t r;
      n = q_in.size(); ip = 0; dpi = 0; cyc = 0; guard = 0; dp = 1'b0;
      r = '{default: '0};
      @(posedge hclk); #1;
      present(d, ip);
      while ((ip < n || dp) && guard < 5000) begin
         @(negedge hclk);
         guard++;
         if (dp) begin
            if (cyc == 0) begin
               r.cs_first = s_cs[d]; r.we = s_we[d]; r.saddr = s_addr[d];
               r.be = s_be[d]; r.wdata = s_wdata[d];
            end else if (s_cs[d] !== 1'b0) begin
               r.extra_cs++;
            end
            if (s_resp[d] !== (q_in[dpi].e_err ? 2'b01 : 2'b00)) r.resp_ok = 1'b0;
            if (s_rdy[d] === 1'b1) begin
               r.rdata = s_rdata[d];
               q_res.push_back(r);
               dp = 1'b0;
            end else begin
               r.low++;
            end
            cyc++;
         end else if (s_cs[d] !== 1'b0 || s_rdy[d] !== 1'b1 || s_resp[d] !== 2'b00) begin
            stray++;
         end
         if (s_rdy[d] === 1'b1 && ip < n) begin
            if (q_in[ip].trans[1]) begin
               dp = 1'b1; dpi = ip; cyc = 0;
               r = '{default: '0};
               r.resp_ok = 1'b1;
            end
            ip++;
         end
         @(posedge hclk); #1;
         present(d, ip);
         m_hwdata[d] = dp ? q_in[dpi].wdata : $urandom;
      end
      if (guard >= 5000) begin
         total++; bad++;
         $display("FAIL run_q dut%0d: got timeout expected completion", d);
      end
      present(d, -1);
   endtask

   task automatic check_run(input string tag);
      res_t r;
      foreach (q_in[i]) begin
         if (q_in[i].trans[1]) begin
            if (q_res.size() == 0) begin
               total++; bad++;
               $display("FAIL %s[%0d]: got no data phase expected one", tag, i);
            end else begin
               r = q_res.pop_front();
               chk($sformatf("%s[%0d] waits", tag, i), 32'(r.low), 32'(q_in[i].e_low));
               chk($sformatf("%s[%0d] hresp", tag, i), 32'(r.resp_ok), 32'(1));
               chk($sformatf("%s[%0d] strobe", tag, i), 32'(r.cs_first), 32'(!q_in[i].e_err));
               chk($sformatf("%s[%0d] extra_cs", tag, i), 32'(r.extra_cs), 32'(0));
               if (!q_in[i].e_err) begin
                  chk($sformatf("%s[%0d] sram_we", tag, i), 32'(r.we), 32'(q_in[i].wr));
                  chk($sformatf("%s[%0d] sram_addr", tag, i), 32'(r.saddr), 32'(q_in[i].e_saddr));
                  chk($sformatf("%s[%0d] sram_be", tag, i), 32'(r.be), 32'(q_in[i].e_be));
                  if (q_in[i].wr)
                     chk($sformatf("%s[%0d] sram_wdata", tag, i), r.wdata, q_in[i].wdata);
                  else
                     chk($sformatf("%s[%0d] hrdata", tag, i), r.rdata, q_in[i].e_rdata);
               end
            end
         end
      end
      chk($sformatf("%s stray", tag), 32'(stray), 32'(0));
      stray = 0;
      q_in.delete();
      q_res.delete();
   endtask

   function automatic logic [7:0] ref_byte(int key);
      if (mref.exists(key)) return mref[key];
      return 8'h00;
   endfunction

   // Reference: lanes and errors derived from byte ranges, memory as bytes.
   task automatic build_rand(input int d, input int n);
      for (int k = 0; k < n; k++) begin
         vec_t v;
         int   sel, nb, base, key;
         v = '{default: '0};
         v.wr    = 1'($urandom);
         v.size  = 3'($urandom_range(0, 2));
         v.wdata = $urandom;
         v.trans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
         v.addr  = 32'h200 + (32'($urandom_range(0, 127)) & ~((32'd1 << v.size) - 1));
         sel = $urandom_range(0, 9);
         if (sel == 0)      v.trans = 2'($urandom_range(0, 1));
         else if (sel == 1) v.addr  = 32'h10000 + 32'($urandom_range(0, 255));
         else if (sel == 2) v.size  = 3'($urandom_range(3, 7));
         else if (sel == 3) v.addr  = v.addr | 32'd1;
         nb = (v.size <= 2) ? (1 << v.size) : 1;
         v.e_err = (v.addr >= 32'(MB)) || (v.size > 2) || ((v.addr % nb) != 0);
         base = int'(v.addr % 4) / nb * nb;
         for (int b = 0; b < nb; b++) v.e_be[base + b] = 1'b1;
         v.e_saddr = 14'(v.addr >> 2);
         v.e_low   = v.e_err ? 1 : (v.wr ? d * 2 : d * 2 + 1);
         if (v.trans[1] && !v.e_err) begin
            key = d * 32'h100000 + int'(v.addr & ~32'd3);
            for (int b = 0; b < 4; b++) begin
               if (v.wr && v.e_be[b]) mref[key + b] = v.wdata[8*b +: 8];
               v.e_rdata[8*b +: 8] = ref_byte(key + b);
            end
         end
         q_in.push_back(v);
      end
   endtask

   vec_t tab0 [17];
   vec_t tab2 [8];

   initial begin
      total = 0; bad = 0; stray = 0;
      for (int d = 0; d < 2; d++) begin
         present(d, -1);
         m_hwdata[d] = '0;
      end

      tab0[0]  = mk(32'h10,    1, 3'd2, 2'b10, 32'hDEADBEEF, 0, 4'hF, 14'd4,  0, 32'h0);
      tab0[1]  = mk(32'h10,    0, 3'd2, 2'b10, 32'h0,        0, 4'hF, 14'd4,  1, 32'hDEADBEEF);
      tab0[2]  = mk(32'h2,     0, 3'd2, 2'b10, 32'h0,        1, 4'h0, 14'd0,  1, 32'h0);
      tab0[3]  = mk(32'h14,    0, 3'd2, 2'b10, 32'h0,        0, 4'hF, 14'd5,  1, 32'h0);
      tab0[4]  = mk(32'h10000, 0, 3'd2, 2'b10, 32'h0,        1, 4'h0, 14'd0,  1, 32'h0);
      tab0[5]  = mk(32'h20,    1, 3'd3, 2'b10, 32'h12345678, 1, 4'h0, 14'd0,  1, 32'h0);
      tab0[6]  = mk(32'h22,    1, 3'd1, 2'b10, 32'hBEEF0000, 0, 4'hC, 14'd8,  0, 32'h0);
      tab0[7]  = mk(32'h21,    0, 3'd1, 2'b10, 32'h0,        1, 4'h0, 14'd0,  1, 32'h0);
      tab0[8]  = mk(32'h20,    0, 3'd2, 2'b10, 32'h0,        0, 4'hF, 14'd8,  1, 32'hBEEF0000);
      tab0[9]  = mk(32'h11,    1, 3'd0, 2'b10, 32'h00005A00, 0, 4'h2, 14'd4,  0, 32'h0);
      tab0[10] = mk(32'h10,    0, 3'd2, 2'b10, 32'h0,        0, 4'hF, 14'd4,  1, 32'hDEAD5AEF);
      tab0[11] = mk(32'h40,    1, 3'd2, 2'b10, 32'h11111111, 0, 4'hF, 14'd16, 0, 32'h0);
      tab0[12] = mk(32'h44,    1, 3'd2, 2'b11, 32'h22222222, 0, 4'hF, 14'd17, 0, 32'h0);
      tab0[13] = mk(32'h48,    1, 3'd2, 2'b01, 32'h0,        0, 4'h0, 14'd0,  0, 32'h0);
      tab0[14] = mk(32'h48,    1, 3'd2, 2'b11, 32'h33333333, 0, 4'hF, 14'd18, 0, 32'h0);
      tab0[15] = mk(32'h4C,    1, 3'd2, 2'b11, 32'h44444444, 0, 4'hF, 14'd19, 0, 32'h0);
      tab0[16] = mk(32'h48,    0, 3'd2, 2'b10, 32'h0,        0, 4'hF, 14'd18, 1, 32'h33333333);

      tab2[0]  = mk(32'h23,    1, 3'd0, 2'b10, 32'hA5000000, 0, 4'h8, 14'd8,  2, 32'h0);
      tab2[1]  = mk(32'h20,    0, 3'd2, 2'b10, 32'h0,        0, 4'hF, 14'd8,  3, 32'hA5000000);
      tab2[2]  = mk(32'h2,     0, 3'd2, 2'b10, 32'h0,        1, 4'h0, 14'd0,  1, 32'h0);
      tab2[3]  = mk(32'h24,    0, 3'd2, 2'b10, 32'h0,        0, 4'hF, 14'd9,  3, 32'h0);
      tab2[4]  = mk(32'h10000, 0, 3'd2, 2'b10, 32'h0,        1, 4'h0, 14'd0,  1, 32'h0);
      tab2[5]  = mk(32'h20,    0, 3'd3, 2'b10, 32'h0,        1, 4'h0, 14'd0,  1, 32'h0);
      tab2[6]  = mk(32'h20,    1, 3'd1, 2'b10, 32'h00001234, 0, 4'h3, 14'd8,  2, 32'h0);
      tab2[7]  = mk(32'h20,    0, 3'd2, 2'b10, 32'h0,        0, 4'hF, 14'd8,  3, 32'hA5001234);

      hreset = 1'b1;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      hreset = 1'b0;
      @(negedge hclk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset%0d hreadyout", d), 32'(s_rdy[d]),  32'(1));
         chk($sformatf("reset%0d hresp", d),     32'(s_resp[d]), 32'(0));
         chk($sformatf("reset%0d hrdata", d),    s_rdata[d],     32'h0);
         chk($sformatf("reset%0d sram_cs", d),   32'(s_cs[d]),   32'(0));
         chk($sformatf("reset%0d sram_we", d),   32'(s_we[d]),   32'(0));
         chk($sformatf("reset%0d sram_be", d),   32'(s_be[d]),   32'(0));
      end

      foreach (tab0[i]) q_in.push_back(tab0[i]);
      run_q(0);
      check_run("w0");
      foreach (tab2[i]) q_in.push_back(tab2[i]);
      run_q(1);
      check_run("w2");

      // Reset during the first wait cycle of a read on the 2-wait instance
      @(posedge hclk); #1;
      m_hsel[1] = 1'b1; m_haddr[1] = 32'h300; m_htrans[1] = 2'b10;
      m_hwrite[1] = 1'b0; m_hsize[1] = 3'd2;
      @(posedge hclk); #1;
      present(1, -1);
      @(negedge hclk);
      chk("rst_wait pre hreadyout", 32'(s_rdy[1]), 32'(0));
      chk("rst_wait pre sram_cs",   32'(s_cs[1]),  32'(1));
      #2 hreset = 1'b1;
      #1;
      chk("rst_wait hreadyout", 32'(s_rdy[1]),  32'(1));
      chk("rst_wait hresp",     32'(s_resp[1]), 32'(0));
      chk("rst_wait hrdata",    s_rdata[1],     32'h0);
      chk("rst_wait sram_cs",   32'(s_cs[1]),   32'(0));
      @(negedge hclk);
      hreset = 1'b0;
      @(negedge hclk);
      chk("rst_wait post hreadyout", 32'(s_rdy[1]), 32'(1));
      chk("rst_wait post sram_cs",   32'(s_cs[1]),  32'(0));

      for (int d = 0; d < 2; d++) begin
         build_rand(d, 80);
         run_q(d);
         check_run($sformatf("rnd%0d", d));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
